fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 4: width of the program counter and instruction memory address.
REQ-002 Parameter INSTR_W, default 8: width of one instruction word.
REQ-003 Port clk, input, 1: rising-edge clock for all state.
REQ-004 Port reset, input, 1: reset, asynchronous, active-high.
REQ-005 Port fetch_en, input, 1: permits new fetches while high.
REQ-006 Port pc_addr, output, ADDR_W: read address driven to the combinational instruction memory; equals the current PC.
REQ-007 Port instr_in, input, INSTR_W: memory read data for pc_addr, valid in the same cycle.
REQ-008 Port branch_valid, input, 1: redirect request, single-cycle pulse.
REQ-009 Port branch_target, input, ADDR_W: new PC, sampled when branch_valid is high.
REQ-010 Port ir_valid, output, 1: instruction register holds a valid instruction.
REQ-011 Port ir_ready, input, 1: decode stage accepts ir_data this cycle.
REQ-012 Port ir_data, output, INSTR_W: instruction register contents.
REQ-013 Port ir_pc, output, ADDR_W: address from which ir_data was fetched.
REQ-014 Port halted, output, 1: fetch stopped on HALT; tied to 0 when FETCH_HALT_EN is undefined.

Function
REQ-015 States: IDLE, RUN, HALTED; HALTED is present only with FETCH_HALT_EN.
REQ-016 IDLE -> RUN on fetch_en=1; RUN -> IDLE on fetch_en=0; while in IDLE, ir_valid still drains normally through the handshake.
REQ-017 A fetch slot exists in RUN when (ir_valid=0 or ir_ready=1) and branch_valid=0.
REQ-018 On a fetch slot: ir_data<=instr_in, ir_pc<=pc_addr, ir_valid<=1, PC<=PC+1.
REQ-019 Fetch latency: instruction at pc_addr appears on ir_data one clock later.
REQ-020 PC increment is modulo 2^ADDR_W; 15 wraps to 0 with no flag and no stall.
REQ-021 Handshake: a transfer occurs on the cycle ir_valid=1 and ir_ready=1; if ir_valid=1 and ir_ready=0, ir_data, ir_pc and PC hold.
REQ-022 Transfer with no fetch slot available: ir_valid<=0 next cycle.
REQ-023 branch_valid=1, in any state except HALTED: PC<=branch_target, ir_valid<=0 next cycle (flush), no fetch that cycle.
REQ-024 A handshake completing in the same cycle as a branch counts as delivered; the flush drops only the following fetch.
REQ-025 branch_valid in IDLE updates PC only; the state does not change.
REQ-026 Throughput: with ir_ready held at 1 and fetch_en held at 1, one instruction is delivered per cycle.

Reset
REQ-027 Asserting reset, at any time including mid-handshake: state=IDLE, PC=0, ir_valid=0, ir_data=0, ir_pc=0, halted=0, immediately and without waiting for clk.
REQ-028 First fetch after reset is from address 0, on the first clk edge with fetch_en=1 and reset low.

Configuration
REQ-029 Macro FETCH_HALT_EN defined: a fetched word equal to HALT_OPCODE (all zeros) is loaded and presented normally, then state->HALTED, PC holds, halted=1; only reset leaves HALTED, and branch_valid is ignored while HALTED.
REQ-030 FETCH_HALT_EN undefined: all-zeros is an ordinary instruction, the HALTED state is absent, and halted=0.

Structure
REQ-031 Shared package fetch_pkg holds the ADDR_W/INSTR_W defaults, the HALT_OPCODE constant and the fetch state enum.
REQ-032 One sub-module, pc_reg, holds the PC with increment, wrap and load-target; all other logic lives in fetch_unit.

Verification
REQ-033 Reset, fetch_en=1, ir_ready=1, memory[0..2]=85,26,D0 (hex) -> ir_data 85,26,D0 on consecutive cycles; ir_pc 0,1,2.
REQ-034 Hold ir_ready=0 for 3 cycles while ir_valid=1, ir_data=26 -> ir_data, ir_pc and pc_addr stable; first beat after release is 26, then D0.
REQ-035 Free-run from PC=14 -> ir_pc sequence 14,15,0,1; no gap cycles.
REQ-036 branch_valid with target=9 while ir_pc=3 and ir_ready=1 -> ir_valid=0 for one cycle, next ir_pc=9.
REQ-037 FETCH_HALT_EN defined, memory[5]=00 -> ir_data=00 delivered, halted=1; pc_addr stays 6; branch to 0 is ignored; reset clears halted.
REQ-038 Reset asserted mid-cycle while ir_valid=1 -> ir_valid=0 and pc_addr=0 before the next clk edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default widths,
// the HALT opcode and the fetch FSM state encoding.
package fetch_pkg;

    localparam int ADDR_W_DEF  = 4;
    localparam int INSTR_W_DEF = 8;

    // All-zeros word stops fetching when FETCH_HALT_EN is defined.
    localparam logic [INSTR_W_DEF-1:0] HALT_OPCODE = '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: load-target beats increment; the increment
// wraps modulo 2^ADDR_W.
// Ports: clk, reset (async, active-high), inc_i, load_i, target_i, pc_o.
module pc_reg
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = target_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads a combinational instruction memory at
// the PC and presents the word in an instruction register with a
// valid/ready handshake toward decode; supports branch redirect/flush.
// Optional feature macro: FETCH_HALT_EN (stop fetching on HALT_OPCODE).
// Ports: clk, reset (async, active-high), fetch_en, pc_addr, instr_in,
//        branch_valid, branch_target, ir_valid, ir_ready, ir_data,
//        ir_pc, halted.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    output logic [ADDR_W-1:0]  pc_addr,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               branch_valid,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [INSTR_W-1:0] ir_data,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               halted
);

    fetch_state_e       state_q, state_d;
    logic               ir_valid_q, ir_valid_d;
    logic [INSTR_W-1:0] ir_data_q, ir_data_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;

    logic xfer;
    logic redirect;
    logic can_fetch;
    logic slot;

`ifdef FETCH_HALT_EN
    localparam logic [INSTR_W-1:0] HALT_W = INSTR_W'(HALT_OPCODE);
`endif

    always_comb begin
        xfer = ir_valid_q & ir_ready;
`ifdef FETCH_HALT_EN
        redirect  = branch_valid && (state_q != ST_HALTED);
        can_fetch = fetch_en && (state_q != ST_HALTED);
`else
        redirect  = branch_valid;
        can_fetch = fetch_en;
`endif
        // fetch_en gates the slot directly so the edge that leaves IDLE
        // already fetches; otherwise reset would cost a bubble.
        slot = can_fetch && (!ir_valid_q || ir_ready) && !branch_valid;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (fetch_en)  state_d = ST_RUN;
            ST_RUN:  if (!fetch_en) state_d = ST_IDLE;
            default: state_d = state_q;
        endcase
`ifdef FETCH_HALT_EN
        if (slot && (instr_in == HALT_W)) begin
            state_d = ST_HALTED;
        end
`endif
    end

    // A handshake on the branch cycle still delivers; only the refill
    // that would have followed is dropped by the flush.
    always_comb begin
        ir_valid_d = ir_valid_q;
        ir_data_d  = ir_data_q;
        ir_pc_d    = ir_pc_q;
        if (slot) begin
            ir_valid_d = 1'b1;
            ir_data_d  = instr_in;
            ir_pc_d    = pc_addr;
        end else if (redirect || xfer) begin
            ir_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ir_valid_q <= 1'b0;
            ir_data_q  <= '0;
            ir_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            ir_valid_q <= ir_valid_d;
            ir_data_q  <= ir_data_d;
            ir_pc_q    <= ir_pc_d;
        end
    end

    pc_reg #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .inc_i    (slot),
        .load_i   (redirect),
        .target_i (branch_target),
        .pc_o     (pc_addr)
    );

    assign ir_valid = ir_valid_q;
    assign ir_data  = ir_data_q;
    assign ir_pc    = ir_pc_q;

`ifdef FETCH_HALT_EN
    assign halted = (state_q == ST_HALTED);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected
// beats; a negedge monitor pops and compares every handshake.
module tb_fetch_unit;

    localparam int AW = 4;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          fetch_en;
    logic [AW-1:0] pc_addr;
    logic [IW-1:0] instr_in;
    logic          branch_valid;
    logic [AW-1:0] branch_target;
    logic          ir_valid;
    logic          ir_ready;
    logic [IW-1:0] ir_data;
    logic [AW-1:0] ir_pc;
    logic          halted;

    logic [IW-1:0] mem [16];

    typedef struct packed {
        logic [IW-1:0] d;
        logic [AW-1:0] p;
    } beat_t;

    beat_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

`ifdef FETCH_HALT_EN
    localparam logic HALT_BUILD = 1'b1;
`else
    localparam logic HALT_BUILD = 1'b0;
`endif

    always #5 clk = ~clk;

    assign instr_in = mem[pc_addr];

    fetch_unit #(
        .ADDR_W  (AW),
        .INSTR_W (IW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_en      (fetch_en),
        .pc_addr       (pc_addr),
        .instr_in      (instr_in),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .ir_valid      (ir_valid),
        .ir_ready      (ir_ready),
        .ir_data       (ir_data),
        .ir_pc         (ir_pc),
        .halted        (halted)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [IW-1:0] d, input logic [AW-1:0] p);
        beat_t b;
        b.d = d;
        b.p = p;
        exp_q.push_back(b);
    endtask

    always @(negedge clk) begin : monitor
        beat_t e;
        if (!reset && ir_valid && ir_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected beat: got %0h@%0d expected none",
                         ir_data, ir_pc);
            end else begin
                e = exp_q.pop_front();
                chk("beat data", 32'(ir_data), 32'(e.d));
                chk("beat pc", 32'(ir_pc), 32'(e.p));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    initial begin
        mem[0]  = 8'h85; mem[1]  = 8'h26; mem[2]  = 8'hD0; mem[3]  = 8'h3C;
        mem[4]  = 8'h4B; mem[5]  = 8'h00; mem[6]  = 8'h66; mem[7]  = 8'h77;
        mem[8]  = 8'h88; mem[9]  = 8'h99; mem[10] = 8'hAA; mem[11] = 8'hBB;
        mem[12] = 8'hCC; mem[13] = 8'hDD; mem[14] = 8'hE1; mem[15] = 8'hF2;

        reset         = 1'b1;
        fetch_en      = 1'b0;
        ir_ready      = 1'b0;
        branch_valid  = 1'b0;
        branch_target = '0;

        tick();
        chk("reset ir_valid", 32'(ir_valid), 0);
        chk("reset pc_addr", 32'(pc_addr), 0);
        chk("reset ir_data", 32'(ir_data), 0);
        chk("reset ir_pc", 32'(ir_pc), 0);
        chk("reset halted", 32'(halted), 0);

        push(8'h85, 4'd0);
        push(8'h26, 4'd1);
        push(8'hD0, 4'd2);
        push(8'h3C, 4'd3);
        push(8'h99, 4'd9);
        push(8'hE1, 4'd14);
        push(8'hF2, 4'd15);
        push(8'h85, 4'd0);
        push(8'h26, 4'd1);

        tick();
        reset    = 1'b0;
        fetch_en = 1'b1;
        ir_ready = 1'b1;
        tick();
        tick();
        ir_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall ir_valid", 32'(ir_valid), 1);
            chk("stall ir_data", 32'(ir_data), 32'h26);
            chk("stall ir_pc", 32'(ir_pc), 1);
            chk("stall pc_addr", 32'(pc_addr), 2);
        end
        tick();
        ir_ready = 1'b1;
        tick();
        tick();
        chk("pre-branch ir_pc", 32'(ir_pc), 3);
        branch_valid  = 1'b1;
        branch_target = 4'd9;
        tick();
        branch_valid = 1'b0;
        @(negedge clk);
        chk("flush ir_valid", 32'(ir_valid), 0);
        chk("branch pc_addr", 32'(pc_addr), 9);
        tick();
        branch_valid  = 1'b1;
        branch_target = 4'd14;
        tick();
        branch_valid = 1'b0;
        @(negedge clk);
        chk("flush2 ir_valid", 32'(ir_valid), 0);
        repeat (4) begin
            @(negedge clk);
            chk("wrap no-gap ir_valid", 32'(ir_valid), 1);
        end
        fetch_en = 1'b0;
        tick();
        @(negedge clk);
        chk("idle drained ir_valid", 32'(ir_valid), 0);
        chk("idle pc_addr", 32'(pc_addr), 2);

        branch_valid  = 1'b1;
        branch_target = 4'd5;
        tick();
        branch_valid = 1'b0;
        @(negedge clk);
        chk("idle branch pc_addr", 32'(pc_addr), 5);
        chk("idle branch ir_valid", 32'(ir_valid), 0);
        tick();
        chk("idle hold pc_addr", 32'(pc_addr), 5);

        push(8'h00, 4'd5);
        if (!HALT_BUILD) push(8'h66, 4'd6);
        fetch_en = 1'b1;
        tick();
        tick();
        fetch_en = 1'b0;
        tick();
        @(negedge clk);
        chk("after zero-word ir_valid", 32'(ir_valid), 0);
        chk("after zero-word pc_addr", 32'(pc_addr), HALT_BUILD ? 6 : 7);
        chk("after zero-word halted", 32'(halted), HALT_BUILD ? 1 : 0);
        branch_valid  = 1'b1;
        branch_target = 4'd0;
        tick();
        branch_valid = 1'b0;
        @(negedge clk);
        chk("branch-0 pc_addr", 32'(pc_addr), HALT_BUILD ? 6 : 0);
        chk("branch-0 halted", 32'(halted), HALT_BUILD ? 1 : 0);

        reset = 1'b1;
        #1;
        chk("reset clears halted", 32'(halted), 0);
        chk("reset clears pc_addr", 32'(pc_addr), 0);
        tick();
        reset    = 1'b0;
        fetch_en = 1'b1;
        ir_ready = 1'b0;
        tick();
        @(negedge clk);
        chk("pre-reset ir_valid", 32'(ir_valid), 1);
        chk("pre-reset ir_data", 32'(ir_data), 32'h85);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset ir_valid", 32'(ir_valid), 0);
        chk("async reset pc_addr", 32'(pc_addr), 0);
        chk("async reset ir_data", 32'(ir_data), 0);
        chk("async reset ir_pc", 32'(ir_pc), 0);
        tick();
        chk("scoreboard drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
